// File: rtl/gray_decoder.sv
// Gray-code position tracker: turns a 2-bit quadrature Gray input into a
// wrapping binary position with direction, step/wrap pulses and a sticky error.
module gray_decoder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             enable,
    input  logic             err_clr,
    input  logic [1:0]       g,
    output logic [WIDTH-1:0] position,
    output logic             dir,
    output logic             step,
    output logic             wrap,
    output logic             error
);

    localparam logic [WIDTH-1:0] POS_MAX = {WIDTH{1'b1}};
    localparam logic [1:0]       DELTA_FWD = 2'd1;
    localparam logic [1:0]       DELTA_BAD = 2'd2;
    localparam logic [1:0]       DELTA_BWD = 2'd3;

    logic [1:0]       r_g_q;
    logic             r_primed;
    logic [WIDTH-1:0] r_position;
    logic             r_dir;
    logic             r_step;
    logic             r_wrap;
    logic             r_error;

    logic [1:0]       w_idx_new;
    logic [1:0]       w_idx_old;
    logic [1:0]       w_delta;
    logic             w_active;

    // Gray code to cyclic index; the modulo-4 difference classifies the move
    assign w_idx_new = {g[1], g[1] ^ g[0]};
    assign w_idx_old = {r_g_q[1], r_g_q[1] ^ r_g_q[0]};
    assign w_delta   = 2'(w_idx_new - w_idx_old);
    assign w_active  = r_primed & enable;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            r_g_q      <= 2'b00;
            r_primed   <= 1'b0;
            r_position <= '0;
            r_dir      <= 1'b0;
            r_step     <= 1'b0;
            r_wrap     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            // Always resample so transitions seen while disabled are dropped
            r_g_q    <= g;
            r_primed <= 1'b1;
            r_step   <= 1'b0;
            r_wrap   <= 1'b0;
            if (err_clr) begin
                r_error <= 1'b0;
            end
            if (w_active) begin
                case (w_delta)
                    DELTA_FWD: begin
                        r_position <= r_position + WIDTH'(1);
                        r_dir      <= 1'b1;
                        r_step     <= 1'b1;
                        r_wrap     <= (r_position == POS_MAX);
                    end
                    DELTA_BWD: begin
                        r_position <= r_position - WIDTH'(1);
                        r_dir      <= 1'b0;
                        r_step     <= 1'b1;
                        r_wrap     <= (r_position == '0);
                    end
                    // A new illegal jump overrides a same-edge clear
                    DELTA_BAD: r_error <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign position = r_position;
    assign dir      = r_dir;
    assign step     = r_step;
    assign wrap     = r_wrap;
    assign error    = r_error;

endmodule

// File: tb/tb_gray_decoder.sv
// Bench for gray_decoder: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the position tracker.
module tb_gray_decoder;

    localparam int unsigned WIDTH = 8;
    localparam int          MOD   = 1 << WIDTH;

    logic             clock;
    logic             clear_n;
    logic             enable;
    logic             err_clr;
    logic [1:0]       g;
    logic [WIDTH-1:0] position;
    logic             dir;
    logic             step;
    logic             wrap;
    logic             error;

    int n_tests;
    int n_fail;

    // Reference model state
    int         m_pos;
    bit         m_dir;
    bit         m_step;
    bit         m_wrap;
    bit         m_err;
    bit         m_primed;
    logic [1:0] m_gq;

    gray_decoder #(.WIDTH(WIDTH)) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .enable   (enable),
        .err_clr  (err_clr),
        .g        (g),
        .position (position),
        .dir      (dir),
        .step     (step),
        .wrap     (wrap),
        .error    (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Position of a code along the forward sequence 00,01,11,10
    function automatic int gidx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model, sample #1 after the edge
    task automatic apply(input bit c, input bit e, input bit clr, input logic [1:0] gv);
        int d;
        clear_n = c;
        enable  = e;
        err_clr = clr;
        g       = gv;
        @(posedge clock);
        if (!c) begin
            m_pos = 0; m_dir = 0; m_step = 0; m_wrap = 0; m_err = 0;
            m_primed = 0; m_gq = 2'b00;
        end else begin
            m_step = 0;
            m_wrap = 0;
            if (clr) m_err = 0;
            if (m_primed && e) begin
                d = (gidx(gv) - gidx(m_gq) + 4) % 4;
                if (d == 1) begin
                    m_wrap = (m_pos == MOD - 1);
                    m_pos  = (m_pos + 1) % MOD;
                    m_dir  = 1;
                    m_step = 1;
                end else if (d == 3) begin
                    m_wrap = (m_pos == 0);
                    m_pos  = (m_pos + MOD - 1) % MOD;
                    m_dir  = 0;
                    m_step = 1;
                end else if (d == 2) begin
                    m_err = 1;
                end
            end
            m_gq     = gv;
            m_primed = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        apply(0, 1, 0, 2'b10);
        apply(0, 1, 0, 2'b10);
        n_tests++;
        if ({position, dir, step, wrap, error} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got pos=%0d dir=%b step=%b wrap=%b err=%b, want all 0",
                     position, dir, step, wrap, error);
        end
        apply(1, 1, 0, 2'b10);
        n_tests++;
        if ({step, error, position} !== {1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_priming: got step=%b err=%b pos=%0d, want 0 0 0", step, error, position);
        end
    endtask

    task automatic test_forward();
        logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        int steps = 0;
        int wraps = 0;
        apply(0, 1, 0, 2'b00);
        apply(1, 1, 0, 2'b00);
        foreach (seq[i]) begin
            apply(1, 1, 0, seq[i]);
            steps += int'(step);
            wraps += int'(wrap);
            n_tests++;
            if ({position, dir, step, wrap, error} !== {WIDTH'(m_pos), m_dir, m_step, m_wrap, m_err}) begin
                n_fail++;
                $display("FAIL fwd_model[%0d]: got pos=%0d dir=%b step=%b wrap=%b, want pos=%0d dir=%b step=%b wrap=%b",
                         i, position, dir, step, wrap, m_pos, m_dir, m_step, m_wrap);
            end
        end
        n_tests++;
        if (steps != 4 || wraps != 0 || position !== 8'd4 || dir !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_run: got steps=%0d wraps=%0d pos=%0d dir=%b, want 4 0 4 1",
                     steps, wraps, position, dir);
        end
    endtask

    task automatic test_backward_wrap();
        apply(0, 1, 0, 2'b00);
        apply(1, 1, 0, 2'b00);
        apply(1, 1, 0, 2'b10);
        n_tests++;
        if ({position, dir, step, wrap} !== {8'd255, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL bwd_wrap: got pos=%0d dir=%b step=%b wrap=%b, want 255 0 1 1",
                     position, dir, step, wrap);
        end
        apply(1, 1, 0, 2'b00);
        n_tests++;
        if ({position, dir, step, wrap} !== {8'd0, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL fwd_wrap: got pos=%0d dir=%b step=%b wrap=%b, want 0 1 1 1",
                     position, dir, step, wrap);
        end
        apply(1, 1, 0, 2'b01);
        n_tests++;
        if ({position, step, wrap} !== {8'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL after_wrap: got pos=%0d step=%b wrap=%b, want 1 1 0", position, step, wrap);
        end
    endtask

    task automatic test_illegal();
        apply(0, 1, 0, 2'b00);
        apply(1, 1, 0, 2'b00);
        apply(1, 1, 0, 2'b11);
        n_tests++;
        if ({error, position, step} !== {1'b1, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_set: got err=%b pos=%0d step=%b, want 1 0 0", error, position, step);
        end
        apply(1, 1, 1, 2'b11);
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clr: got err=%b, want 0", error);
        end
        apply(1, 1, 1, 2'b00);
        n_tests++;
        if ({error, position, step} !== {1'b1, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL set_beats_clr: got err=%b pos=%0d step=%b, want 1 0 0", error, position, step);
        end
    endtask

    task automatic test_enable();
        apply(0, 1, 0, 2'b00);
        apply(1, 1, 0, 2'b00);
        apply(1, 0, 0, 2'b01);
        apply(1, 0, 0, 2'b11);
        n_tests++;
        if ({position, dir, step, wrap, error} !== '0) begin
            n_fail++;
            $display("FAIL disabled: got pos=%0d dir=%b step=%b wrap=%b err=%b, want all 0",
                     position, dir, step, wrap, error);
        end
        apply(1, 1, 0, 2'b11);
        n_tests++;
        if ({position, step} !== {8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reenable: got pos=%0d step=%b, want 0 0", position, step);
        end
        apply(1, 1, 0, 2'b10);
        n_tests++;
        if ({position, dir, step} !== {8'd1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL after_enable: got pos=%0d dir=%b step=%b, want 1 1 1", position, dir, step);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] seq [7] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
        apply(0, 1, 0, 2'b00);
        apply(1, 1, 0, 2'b00);
        foreach (seq[i]) apply(1, 1, 0, seq[i]);
        apply(1, 1, 0, 2'b01);
        n_tests++;
        if ({position, error} !== {8'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_setup: got pos=%0d err=%b, want 7 1", position, error);
        end
        apply(0, 1, 0, 2'b01);
        n_tests++;
        if ({position, dir, step, wrap, error} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got pos=%0d dir=%b step=%b wrap=%b err=%b, want all 0",
                     position, dir, step, wrap, error);
        end
        apply(1, 1, 0, 2'b01);
        n_tests++;
        if ({position, step} !== {8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_prime: got pos=%0d step=%b, want 0 0", position, step);
        end
        apply(1, 1, 0, 2'b11);
        n_tests++;
        if (position !== 8'd1) begin
            n_fail++;
            $display("FAIL mid_resume: got pos=%0d, want 1", position);
        end
    endtask

    task automatic test_random();
        logic [1:0] gv;
        int r;
        apply(0, 1, 0, 2'b00);
        gv = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            // Mostly legal steps so the counter travels through both wraps
            if (r < 45)      gv = (gv == 2'b00) ? 2'b01 : (gv == 2'b01) ? 2'b11 : (gv == 2'b11) ? 2'b10 : 2'b00;
            else if (r < 85) gv = (gv == 2'b00) ? 2'b10 : (gv == 2'b10) ? 2'b11 : (gv == 2'b11) ? 2'b01 : 2'b00;
            else             gv = 2'($urandom);
            apply(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 15) == 0), gv);
            n_tests++;
            if ({position, dir, step, wrap, error} !== {WIDTH'(m_pos), m_dir, m_step, m_wrap, m_err}) begin
                n_fail++;
                $display("FAIL random[%0d]: got pos=%0d dir=%b step=%b wrap=%b err=%b, want pos=%0d dir=%b step=%b wrap=%b err=%b",
                         i, position, dir, step, wrap, error, m_pos, m_dir, m_step, m_wrap, m_err);
            end
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        clear_n  = 1'b0;
        enable   = 1'b0;
        err_clr  = 1'b0;
        g        = 2'b00;
        m_pos    = 0; m_dir = 0; m_step = 0; m_wrap = 0; m_err = 0;
        m_primed = 0; m_gq = 2'b00;
        test_reset();
        test_forward();
        test_backward_wrap();
        test_illegal();
        test_enable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
